clk_div_cfg_ctrl: RTL

Configuration controller for the clock divider: arbitrates division-ratio change requests from two requesters and sequences each change safely. For each change it holds the divider in bypass, loads the new ratio, re-enables the divider, then confirms lock by counting rising edges of the fed-back divided clock. It sits between the prescale-owning blocks and the divider's `enable` / `division_ratio` inputs, and is the only driver of those inputs.

---
 rtl/clk_div_cfg_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/clk_div_cfg_ctrl.sv
// Clock-divider configuration controller: arbitrates two ratio-change requesters and sequences
// bypass, load, re-enable and lock confirmation. Define CLK_DIV_CTRL_RR_EN for round-robin arbitration.
module clk_div_cfg_ctrl #(
  parameter int unsigned DIV_W         = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_EDGES    = 2,
  parameter int unsigned LOCK_TIMEOUT  = 64
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [DIV_W-1:0] req_ratio0,
  input  logic [DIV_W-1:0] req_ratio1,
  output logic [1:0]       ack,
  output logic             err,
  output logic             busy,
  output logic             locked,
  output logic             div_enable,
  output logic [DIV_W-1:0] div_ratio,
  input  logic             div_clk_mon
);

  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned EDGE_W = $clog2(LOCK_EDGES + 1);
  localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_STOP, S_LOAD, S_START, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic              idx, idx_nxt;
  logic [DIV_W-1:0]  lat_ratio, lat_ratio_nxt;
  logic [SET_W-1:0]  set_cnt, set_cnt_nxt;
  logic [EDGE_W-1:0] edge_cnt, edge_cnt_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic [1:0]        ack_nxt;
  logic              err_nxt, busy_nxt, locked_nxt, en_nxt;
  logic [DIV_W-1:0]  ratio_nxt;
  logic              mon_s1, mon_s2, mon_s3, mon_rise_c;
  logic              win_c;
  logic [DIV_W-1:0]  win_ratio_c;

  function automatic logic [1:0] onehot(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

`ifdef CLK_DIV_CTRL_RR_EN
  // Round-robin: the requester after the pointer wins; pointer follows the winner.
  logic rr_ptr;

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b1;
    end else if (state == S_IDLE && req != 2'b00) begin
      rr_ptr <= win_c;
    end
  end

  always_comb begin
    win_c = rr_ptr ? ~req[0] : req[1];
  end
`else
  // Fixed priority: requester 0 always wins.
  always_comb begin
    win_c = ~req[0];
  end
`endif

  always_comb begin
    win_ratio_c = win_c ? req_ratio1 : req_ratio0;
  end

  // Fed-back divided clock: two-flop synchronizer plus edge-detect flop.
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      mon_s1 <= 1'b0;
      mon_s2 <= 1'b0;
      mon_s3 <= 1'b0;
    end else begin
      mon_s1 <= div_clk_mon;
      mon_s2 <= mon_s1;
      mon_s3 <= mon_s2;
    end
  end

  always_comb begin
    mon_rise_c = mon_s2 & ~mon_s3;
  end

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= 1'b0;
      lat_ratio  <= '0;
      set_cnt    <= '0;
      edge_cnt   <= '0;
      to_cnt     <= '0;
      ack        <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      div_enable <= 1'b0;
      div_ratio  <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      lat_ratio  <= lat_ratio_nxt;
      set_cnt    <= set_cnt_nxt;
      edge_cnt   <= edge_cnt_nxt;
      to_cnt     <= to_cnt_nxt;
      ack        <= ack_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
      locked     <= locked_nxt;
      div_enable <= en_nxt;
      div_ratio  <= ratio_nxt;
    end
  end

  // Next state and next registered outputs; outputs take effect on entry to the next state.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    lat_ratio_nxt = lat_ratio;
    set_cnt_nxt   = set_cnt;
    edge_cnt_nxt  = edge_cnt;
    to_cnt_nxt    = to_cnt;
    ack_nxt       = 2'b00;
    err_nxt       = err;
    locked_nxt    = locked;
    en_nxt        = div_enable;
    ratio_nxt     = div_ratio;

    unique case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          idx_nxt       = win_c;
          lat_ratio_nxt = win_ratio_c;
          if (win_ratio_c == div_ratio) begin
            locked_nxt = 1'b1;
            err_nxt    = 1'b0;
            ack_nxt    = onehot(win_c);
            state_nxt  = S_DONE;
          end else begin
            state_nxt = S_GRANT;
          end
        end
      end
      S_GRANT: begin
        err_nxt     = 1'b0;
        locked_nxt  = 1'b0;
        en_nxt      = 1'b0;
        set_cnt_nxt = '0;
        state_nxt   = S_STOP;
      end
      S_STOP: begin
        set_cnt_nxt = set_cnt + SET_W'(1);
        if (set_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        ratio_nxt    = lat_ratio;
        edge_cnt_nxt = '0;
        to_cnt_nxt   = '0;
        if (lat_ratio < DIV_W'(2)) begin
          locked_nxt = 1'b1;
          ack_nxt    = onehot(idx);
          state_nxt  = S_DONE;
        end else begin
          en_nxt    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        to_cnt_nxt = to_cnt + TO_W'(1);
        if (mon_rise_c) begin
          edge_cnt_nxt = edge_cnt + EDGE_W'(1);
        end
        if (mon_rise_c && edge_cnt == EDGE_W'(LOCK_EDGES - 1)) begin
          locked_nxt = 1'b1;
          ack_nxt    = onehot(idx);
          state_nxt  = S_DONE;
        end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
          ack_nxt    = onehot(idx);
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
